// File: rtl/rbs_subtractor_serial.sv
`default_nettype none
// ============================================================================
//  Module      : rbs_subtractor_serial
//  Description : Bit-serial ripple-borrow subtractor. Computes A - B - Bin
//                one bit per enabled clock, LSB first. Start/busy/done
//                handshake; result outputs are masked to zero while en=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rbs_subtractor_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Ovf
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   d_sh_q,   d_sh_d;
    logic               bw_q,     bw_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               a_msb_q,  a_msb_d;
    logic               b_msb_q,  b_msb_d;
    logic [WIDTH-1:0]   diff_q,   diff_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q,    ovf_d;
    logic               done_q,   done_d;

    // One full-subtractor slice working on the current LSBs of the shifters
    logic               w_a0;
    logic               w_b0;
    logic               w_d;
    logic               w_bw_next;
    logic [WIDTH-1:0]   w_d_sh_next;

    assign w_a0        = a_sh_q[0];
    assign w_b0        = b_sh_q[0];
    assign w_d         = w_a0 ^ w_b0 ^ bw_q;
    assign w_bw_next   = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & bw_q);
    assign w_d_sh_next = {w_d, d_sh_q[WIDTH-1:1]};

    // Next-state logic: accept a start in IDLE, shift one bit per enabled cycle
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        bw_d     = bw_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;    // done is a single-cycle pulse

        case (state_q)
            IDLE: begin
                if (start && en) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    bw_d    = Bin;
                    d_sh_d  = '0;
                    cnt_d   = '0;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // en low freezes the whole datapath, including the counter
                if (en) begin
                    a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                    d_sh_d = w_d_sh_next;
                    bw_d   = w_bw_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        // The bit produced on this edge is the result MSB
                        diff_d   = w_d_sh_next;
                        borrow_d = w_bw_next;
                        ovf_d    = (a_msb_q ^ b_msb_q) & (w_d ^ a_msb_q);
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            bw_q     <= bw_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = done_q;
    // Result outputs read zero while disabled; the registers keep their value
    assign Diff   = en ? diff_q   : '0;
    assign Borrow = en ? borrow_q : 1'b0;
    assign Ovf    = en ? ovf_q    : 1'b0;

endmodule
`default_nettype wire
